// File: rtl/uart_io_pkg.sv
// Shared definitions for the buffered UART I/O unit: FSM encodings and
// width helpers used by the FIFOs and the core-side FSMs.
package uart_io_pkg;

    typedef enum logic [1:0] {R_IDLE, R_POP, R_ACK} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_PUSH, W_ACK} wr_state_t;
    typedef enum logic [1:0] {D_IDLE, D_GUARD, D_WAIT} dr_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int bytes_of(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/full/empty and show-ahead read data.
// A push on full is accepted when a pop is taken in the same cycle.
module sync_fifo
    import uart_io_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [clog2(DEPTH):0]  count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (!do_push && do_pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/uart_io_buffer.sv
// Buffered UART I/O between the core and the uart_rx / uart_tx_top PHYs.
// Core handshake: rd_req/wr_req are levels held until the one-cycle ack.
module uart_io_buffer
    import uart_io_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int RX_DEPTH = 512,
    parameter int TX_DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_valid,
    output logic [7:0]               tx_byte,
    output logic                     tx_start,
    input  logic                     tx_busy,
    input  logic                     rd_req,
    input  logic                     rd_word,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_ack,
    input  logic                     wr_req,
    input  logic                     wr_word,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ack,
    output logic [clog2(RX_DEPTH):0] rx_count,
    output logic                     rx_overflow,
    input  logic                     ovf_clr,
    output logic                     tx_empty
);

    localparam int BYTES = bytes_of(DATA_W);
    localparam int KW    = clog2(BYTES) + 1;
    localparam logic [KW-1:0] N_WORD = KW'(BYTES);
    localparam logic [KW-1:0] N_BYTE = KW'(1);

    rd_state_t rd_state;
    wr_state_t wr_state;
    dr_state_t dr_state;

    // RX path
    logic       rx_pop;
    logic       rx_full;
    logic       rx_empty;
    logic [7:0] rx_dout;
    logic       rx_drop;

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (rx_valid),
        .din   (rx_byte),
        .pop   (rx_pop),
        .dout  (rx_dout),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign rx_pop  = (rd_state == R_POP) && !rx_empty;
    assign rx_drop = rx_valid && rx_full && !rx_pop;

    // A drop in the same cycle as a clear wins, so no lost byte goes unreported.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            rx_overflow <= 1'b0;
        else if (rx_drop)
            rx_overflow <= 1'b1;
        else if (ovf_clr)
            rx_overflow <= 1'b0;
    end

    // Read FSM
    logic [KW-1:0]     rd_n;
    logic [KW-1:0]     rd_k;
    logic [DATA_W-1:0] rd_asm;
    logic [DATA_W-1:0] rd_asm_nxt;
    logic              rd_hold;

    always_comb begin
        rd_asm_nxt = rd_asm;
        rd_asm_nxt[8*rd_k +: 8] = rx_dout;
    end

    // rd_hold skips the cycle after R_ACK, while the core is still dropping rd_req.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state <= R_IDLE;
            rd_n     <= '0;
            rd_k     <= '0;
            rd_asm   <= '0;
            rd_data  <= '0;
            rd_ack   <= 1'b0;
            rd_hold  <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    rd_ack <= 1'b0;
                    if (rd_hold) begin
                        rd_hold <= 1'b0;
                    end else if (rd_req) begin
                        rd_n     <= rd_word ? N_WORD : N_BYTE;
                        rd_k     <= '0;
                        rd_asm   <= '0;
                        rd_state <= R_POP;
                    end
                end
                R_POP: begin
                    if (!rx_empty) begin
                        rd_asm <= rd_asm_nxt;
                        rd_k   <= rd_k + 1'b1;
                        if (rd_k == rd_n - 1'b1) begin
                            rd_data  <= rd_asm_nxt;
                            rd_ack   <= 1'b1;
                            rd_state <= R_ACK;
                        end
                    end
                end
                R_ACK: begin
                    rd_ack   <= 1'b0;
                    rd_hold  <= 1'b1;
                    rd_state <= R_IDLE;
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // TX path
    logic                      tx_push;
    logic                      tx_pop;
    logic                      tx_full;
    logic                      tx_fifo_empty;
    logic [7:0]                tx_dout;
    logic [clog2(TX_DEPTH):0]  tx_count;
    logic [DATA_W-1:0]         wr_buf;
    logic [KW-1:0]             wr_n;
    logic [KW-1:0]             wr_k;
    logic                      wr_hold;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (tx_push),
        .din   (wr_buf[7:0]),
        .pop   (tx_pop),
        .dout  (tx_dout),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_fifo_empty)
    );

    assign tx_push  = (wr_state == W_PUSH) && (!tx_full || tx_pop);
    assign tx_pop   = (dr_state == D_IDLE) && !tx_fifo_empty && !tx_busy;
    assign tx_empty = (tx_count == '0) && (dr_state == D_IDLE);

    // Write FSM: wr_buf shifts right so the next byte is always in [7:0].
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_state <= W_IDLE;
            wr_buf   <= '0;
            wr_n     <= '0;
            wr_k     <= '0;
            wr_ack   <= 1'b0;
            wr_hold  <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    wr_ack <= 1'b0;
                    if (wr_hold) begin
                        wr_hold <= 1'b0;
                    end else if (wr_req) begin
                        wr_buf   <= wr_data;
                        wr_n     <= wr_word ? N_WORD : N_BYTE;
                        wr_k     <= '0;
                        wr_state <= W_PUSH;
                    end
                end
                W_PUSH: begin
                    if (tx_push) begin
                        wr_buf <= wr_buf >> 8;
                        wr_k   <= wr_k + 1'b1;
                        if (wr_k == wr_n - 1'b1) begin
                            wr_ack   <= 1'b1;
                            wr_state <= W_ACK;
                        end
                    end
                end
                W_ACK: begin
                    wr_ack   <= 1'b0;
                    wr_hold  <= 1'b1;
                    wr_state <= W_IDLE;
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Drain FSM: D_GUARD masks the PHY's delay in raising tx_busy after tx_start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dr_state <= D_IDLE;
            tx_byte  <= 8'h00;
            tx_start <= 1'b0;
        end else begin
            case (dr_state)
                D_IDLE: begin
                    tx_start <= 1'b0;
                    if (tx_pop) begin
                        tx_byte  <= tx_dout;
                        tx_start <= 1'b1;
                        dr_state <= D_GUARD;
                    end
                end
                D_GUARD: begin
                    tx_start <= 1'b0;
                    dr_state <= D_WAIT;
                end
                D_WAIT: begin
                    if (!tx_busy) dr_state <= D_IDLE;
                end
                default: dr_state <= D_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_io_buffer.sv
// Scoreboard bench for uart_io_buffer: reads and PHY transmissions are checked
// against a byte-queue model of the RX/TX streams.
module tb_uart_io_buffer;

    localparam int DATA_W   = 32;
    localparam int RX_DEPTH = 4;
    localparam int TX_DEPTH = 8;
    localparam int BYTES    = DATA_W / 8;

    logic                        clk;
    logic                        rstn;
    logic [7:0]                  rx_byte;
    logic                        rx_valid;
    logic [7:0]                  tx_byte;
    logic                        tx_start;
    logic                        tx_busy;
    logic                        rd_req;
    logic                        rd_word;
    logic [DATA_W-1:0]           rd_data;
    logic                        rd_ack;
    logic                        wr_req;
    logic                        wr_word;
    logic [DATA_W-1:0]           wr_data;
    logic                        wr_ack;
    logic [$clog2(RX_DEPTH):0]   rx_count;
    logic                        rx_overflow;
    logic                        ovf_clr;
    logic                        tx_empty;

    uart_io_buffer #(.DATA_W(DATA_W), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .tx_byte     (tx_byte),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .rd_req      (rd_req),
        .rd_word     (rd_word),
        .rd_data     (rd_data),
        .rd_ack      (rd_ack),
        .wr_req      (wr_req),
        .wr_word     (wr_word),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .rx_count    (rx_count),
        .rx_overflow (rx_overflow),
        .ovf_clr     (ovf_clr),
        .tx_empty    (tx_empty)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_rd;
    int t_wr;

    logic [DATA_W-1:0] rd_exp_q[$];
    logic [7:0]        tx_exp_q[$];
    logic [7:0]        rx_model[$];
    bit                ovf_model;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- PHY model: busy 20 cycles, raised one cycle after tx_start ----
    int busy_cnt = 0;
    bit arm = 0;
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (busy_cnt > 0) busy_cnt--;
            if (arm) begin
                busy_cnt = 20;
                arm = 0;
            end
            tx_busy = (busy_cnt > 0);
            if (tx_start) arm = 1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rd_ack) begin
            if (rd_exp_q.size() == 0) check("rd_unexpected_ack", rd_ack, 0);
            else check("rd_data", rd_data, rd_exp_q.pop_front());
        end
        if (tx_start) begin
            check("tx_start_while_busy", tx_busy, 0);
            if (tx_exp_q.size() == 0) check("tx_unexpected_start", tx_start, 0);
            else check("tx_byte", tx_byte, tx_exp_q.pop_front());
        end
    end

    // ---------------- reference model helpers ----------------
    function automatic logic [DATA_W-1:0] model_take(input bit word);
        logic [DATA_W-1:0] v;
        int n;
        v = '0;
        n = word ? BYTES : 1;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rx_model.pop_front();
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_rx(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        if (rx_model.size() < RX_DEPTH) rx_model.push_back(b);
        else ovf_model = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic rd_start(input bit word, input logic [DATA_W-1:0] exp);
        rd_word = word;
        rd_req  = 1'b1;
        rd_exp_q.push_back(exp);
        t_rd = cyc;
    endtask

    task automatic rd_wait(input string name, input int exp_lat);
        int lat;
        for (int k = 0; k < 500 && !rd_ack; k++) tick();
        if (!rd_ack) begin
            check({name, "_timeout"}, rd_ack, 1);
            rd_req = 1'b0;
        end else begin
            lat = cyc - t_rd;
            rd_req = 1'b0;
            if (exp_lat >= 0) check(name, lat, exp_lat);
        end
        tick();
        tick();
    endtask

    task automatic wr_start(input bit word, input logic [DATA_W-1:0] data);
        int n;
        wr_word = word;
        wr_data = data;
        wr_req  = 1'b1;
        n = word ? BYTES : 1;
        for (int i = 0; i < n; i++) tx_exp_q.push_back(data[8*i +: 8]);
        t_wr = cyc;
    endtask

    task automatic wr_wait(input string name, input int exp_lat);
        int lat;
        for (int k = 0; k < 2000 && !wr_ack; k++) tick();
        if (!wr_ack) begin
            check({name, "_timeout"}, wr_ack, 1);
            wr_req = 1'b0;
        end else begin
            lat = cyc - t_wr;
            wr_req = 1'b0;
            if (exp_lat >= 0) check(name, lat, exp_lat);
        end
        tick();
        tick();
    endtask

    task automatic pulse_ovf_clr();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        ovf_model = 1'b0;
    endtask

    task automatic wait_tx_empty();
        for (int k = 0; k < 3000 && !(tx_empty && tx_exp_q.size() == 0); k++) tick();
        check("tx_empty_returns", tx_empty, 1);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        logic [7:0]        b [4];
        logic [DATA_W-1:0] exp_w;
        int                op;
        bit                word;

        rstn = 1'b0; rx_byte = '0; rx_valid = 0; rd_req = 0; rd_word = 0;
        wr_req = 0; wr_word = 0; wr_data = '0; ovf_clr = 0; ovf_model = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_ack", rd_ack, 0);
        check("rst_wr_ack", wr_ack, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_rx_overflow", rx_overflow, 0);
        check("rst_tx_empty", tx_empty, 1);
        check("rst_rx_count", rx_count, 0);
        rstn = 1'b1;
        tick();

        // Byte read
        send_rx(8'h41);
        check("byte_rd_count_before", rx_count, 1);
        rd_start(1'b0, model_take(1'b0));
        rd_wait("byte_rd_latency", 2);
        check("byte_rd_value", rd_data, 32'h0000_0041);
        check("byte_rd_count_after", rx_count, 0);

        // Word read, little-endian
        send_rx(8'h78); send_rx(8'h56); send_rx(8'h34); send_rx(8'h12);
        check("word_rd_count", rx_count, 4);
        rd_start(1'b1, model_take(1'b1));
        rd_wait("word_rd_latency", 5);
        check("word_rd_value", rd_data, 32'h1234_5678);

        // Starved word read: last two bytes arrive 10 cycles after the request
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 255));
        exp_w = {b[3], b[2], b[1], b[0]};
        send_rx(b[0]); send_rx(b[1]);
        rd_start(1'b1, exp_w);
        repeat (10) tick();
        send_rx(b[2]); send_rx(b[3]);
        rx_model.delete();
        rd_wait("starved_rd_latency", 13);

        // Overflow: fifth byte dropped
        for (int i = 0; i < 5; i++) send_rx(8'($urandom_range(0, 255)));
        check("ovf_rx_count", rx_count, 4);
        check("ovf_flag_set", rx_overflow, ovf_model);
        pulse_ovf_clr();
        check("ovf_flag_cleared", rx_overflow, 0);
        rx_byte = 8'hA5; rx_valid = 1'b1; ovf_clr = 1'b1;
        tick();
        rx_valid = 1'b0; ovf_clr = 1'b0;
        check("ovf_set_beats_clear", rx_overflow, 1);
        check("ovf_full_count_held", rx_count, 4);
        for (int i = 0; i < 4; i++) begin
            rd_start(1'b0, model_take(1'b0));
            rd_wait("ovf_drain_latency", 2);
        end
        pulse_ovf_clr();
        check("ovf_flag_cleared2", rx_overflow, 0);

        // Word write through the PHY model
        wr_start(1'b1, 32'hDEAD_BEEF);
        wr_wait("word_wr_latency", 5);
        check("tx_empty_while_sending", tx_empty, 0);
        wait_tx_empty();

        // Reset in the middle of a word read
        send_rx(8'h11); send_rx(8'h22); send_rx(8'h33);
        rd_start(1'b1, '0);
        tick(); tick(); tick();
        rstn = 1'b0;
        #1;
        rd_req = 1'b0;
        rd_exp_q.delete();
        rx_model.delete();
        ovf_model = 1'b0;
        check("midrst_rx_count", rx_count, 0);
        check("midrst_rd_data", rd_data, 0);
        check("midrst_rd_ack", rd_ack, 0);
        tick();
        rstn = 1'b1;
        repeat (6) tick();
        for (int i = 0; i < 4; i++) send_rx(8'($urandom_range(0, 255)));
        rd_start(1'b1, model_take(1'b1));
        rd_wait("post_rst_rd_latency", 5);

        // Randomized mix of pushes, reads, writes and status checks
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    for (int i = 0; i < int'($urandom_range(1, 3)); i++)
                        send_rx(8'($urandom_range(0, 255)));
                end
                1: begin
                    word = 1'($urandom_range(0, 1));
                    if (rx_model.size() >= (word ? BYTES : 1)) begin
                        rd_start(word, model_take(word));
                        rd_wait("rand_rd_latency", word ? BYTES + 1 : 2);
                    end
                end
                2: begin
                    wr_start(1'($urandom_range(0, 1)), $urandom);
                    wr_wait("rand_wr", -1);
                end
                default: begin
                    check("rand_rx_count", rx_count, rx_model.size());
                    check("rand_rx_overflow", rx_overflow, ovf_model);
                    if ($urandom_range(0, 1) == 1) pulse_ovf_clr();
                end
            endcase
        end

        wait_tx_empty();
        check("tx_queue_drained", tx_exp_q.size(), 0);
        check("rd_queue_drained", rd_exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
